pipe_latch: RTL

PIPE_LATCH -- requirements
Module: pipe_latch

---
 rtl/pipeline_reg_pkg.sv | 57 +++++
 rtl/sat_counter.sv | 26 ++
 rtl/pipe_latch.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipeline_reg_pkg.sv
// Shared types for the CPU pipeline registers: the latch state encoding,
// the per-stage payload structs and a few helpers used by pipe_latch.
package pipeline_reg_pkg;

    // Occupancy-oriented state of a pipe_latch: nothing held, main slot
    // only, or main plus skid slot.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } latch_state_t;

    localparam int STALL_CNT_W = 16;

    // Stage payloads carried between pipeline stages.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_p;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } idex_p;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } exmem_p;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_p;

    // Number of entries held in a given state.
    function automatic logic [1:0] state_occupancy(input latch_state_t s);
        case (s)
            BUSY:    return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_reg;

    assign count = count_reg;

    // Count qualifying cycles, holding once the maximum value is reached.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + ONE;
        end
    end

endmodule

// File: rtl/pipe_latch.sv
// Pipeline register between two CPU stages with valid/ready handshakes on
// both sides, flush (squash) and freeze (global hold). DEPTH=1 is a plain
// latch whose in_ready depends combinationally on out_ready; DEPTH=2 adds a
// skid slot so that in_ready can come straight from a flop.
module pipe_latch
    import pipeline_reg_pkg::*;
#(
    parameter int               WIDTH  = 64,
    parameter int               DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             freeze,
    output logic [1:0]       occupancy,
    output logic [15:0]      stall_cnt
);

    latch_state_t     state_reg, state_next;
    logic [WIDTH-1:0] main_reg, main_next;
    logic [WIDTH-1:0] skid_reg, skid_next;
    logic             in_xfer;
    logic             out_xfer;
    logic             stall_inc;

    // Freeze hides the held entry from downstream without disturbing it.
    assign out_valid = (state_reg != EMPTY) && !freeze;
    assign out_data  = out_valid ? main_reg : BUBBLE;
    assign occupancy = state_occupancy(state_reg);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign stall_inc = out_valid && !out_ready;

    // Next-state and slot update; flush dominates everything, including freeze.
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
            state_next = EMPTY;
            main_next  = BUBBLE;
            skid_next  = BUBBLE;
        end else if (!freeze) begin
            case (state_reg)
                EMPTY: begin
                    if (in_xfer) begin
                        state_next = BUSY;
                        main_next  = in_data;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_next = in_data;
                    end else if (in_xfer) begin
                        state_next = FULL;
                        skid_next  = in_data;
                    end else if (out_xfer) begin
                        state_next = EMPTY;
                        main_next  = BUBBLE;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_xfer) begin
                        state_next = BUSY;
                        main_next  = skid_reg;
                        skid_next  = BUBBLE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_next  = BUBBLE;
                    skid_next  = BUBBLE;
                end
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg <= EMPTY;
            main_reg  <= BUBBLE;
            skid_reg  <= BUBBLE;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

    generate
        if (DEPTH == 1) begin : g_plain
            assign in_ready = !freeze && (!out_valid || out_ready);
        end else if (DEPTH == 2) begin : g_skid
            logic in_ready_reg;

            // Ready for the next cycle as long as the skid slot will be free.
            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    in_ready_reg <= 1'b1;
                end else begin
                    in_ready_reg <= (state_next != FULL);
                end
            end

            assign in_ready = in_ready_reg && !freeze;
        end else begin : g_bad_depth
            $error("pipe_latch: DEPTH must be 1 or 2");
        end
    endgenerate

    sat_counter #(
        .W(STALL_CNT_W)
    ) u_stall_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (stall_inc),
        .count(stall_cnt)
    );

endmodule
